// File: rtl/buf_audio_pkg.sv
// Shared types, frame constants and sample width helpers for the I2S transmit path.
package buf_audio_pkg;

  localparam int DEF_I2S_WIDTH   = 24;
  localparam int SLOTS_PER_FRAME = 2 * DEF_I2S_WIDTH;
  localparam int MAX_SAMPLE_W    = 64;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } lr_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } tx_state_t;

  // Returns the slot word right-aligned in the low iw bits: zero LSBs when the
  // sample is narrower than the slot, dropped LSBs when it is wider.
  function automatic logic [MAX_SAMPLE_W-1:0] pad_sample(
    input logic [MAX_SAMPLE_W-1:0] s,
    input int                      aw,
    input int                      iw
  );
    if (aw >= iw) return s >> (aw - iw);
    else          return s << (iw - aw);
  endfunction

  // Word select leads the data by one slot.
  function automatic lr_sel_t slot_channel(input int slot, input int iw);
    return (((slot + 1) % (2 * iw)) >= iw) ? RIGHT : LEFT;
  endfunction

endpackage

// File: rtl/sample_pair_fifo.sv
// Synchronous FIFO of {left,right} sample pairs with registered full/empty flags.
module sample_pair_fifo #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_wr;
  logic              w_rd;
  logic [AW:0]       w_count_nxt;

  // A write while full is dropped even if a read frees a slot in the same cycle.
  assign w_wr = i_wr_en && !r_full;
  assign w_rd = i_rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd)      w_count_nxt = r_count + 1'b1;
    else if (w_rd && !w_wr) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW + 1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/buf_audio_out.sv
// I2S master transmitter: sample-pair FIFO, bclk divider, slot counter and frame shifter.
// Handshake: a pair is taken on a rising edge where sample_valid && buffer_ready; buffer_ready = !buffer_full.
module buf_audio_out
  import buf_audio_pkg::*;
#(
  parameter int I2S_WIDTH    = SLOTS_PER_FRAME / 2,
  parameter int AUDIO_WIDTH  = 24,
  parameter int BUFFER_DEPTH = 4,
  parameter int BCLK_DIV     = 2
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   tx_enable,
  input  logic [AUDIO_WIDTH-1:0] audio_left_in,
  input  logic [AUDIO_WIDTH-1:0] audio_right_in,
  input  logic                   sample_valid,
  output logic                   buffer_ready,
  output logic                   buffer_full,
  output logic                   buffer_empty,
  output logic                   underrun,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_data,
  output logic [1:0]             o_dbg_state
);

  localparam int SLOTS = 2 * I2S_WIDTH;
  localparam int SW    = $clog2(SLOTS);
  localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CW    = $clog2(BUFFER_DEPTH) + 1;

  tx_state_t                r_state;
  logic [DW-1:0]            r_div_cnt;
  logic [SW-1:0]            r_slot;
  logic [SLOTS-1:0]         r_frame_sr;
  logic                     r_bclk;
  logic                     r_lrclk;
  logic                     r_data;
  logic                     r_underrun;
  logic                     r_stop;

  logic [2*AUDIO_WIDTH-1:0] w_head;
  logic                     w_full;
  logic                     w_empty;
  logic [CW-1:0]            w_count;
  logic                     w_tc;
  logic                     w_fall;
  logic                     w_last_slot;
  logic                     w_stop;
  logic                     w_pop;
  logic                     w_have_pair;
  logic [SLOTS-1:0]         w_load;
  logic [SW-1:0]            w_next_slot;

  sample_pair_fifo #(
    .DATA_W (2 * AUDIO_WIDTH),
    .DEPTH  (BUFFER_DEPTH)
  ) u_fifo (
    .i_clk     (sys_clk),
    .i_rst     (sys_rst),
    .i_wr_en   (sample_valid),
    .i_wr_data ({audio_left_in, audio_right_in}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign w_tc        = (r_div_cnt == DW'(BCLK_DIV - 1));
  assign w_fall      = (r_state != IDLE) && w_tc && r_bclk;
  assign w_last_slot = (r_slot == SW'(SLOTS - 1));
  assign w_stop      = r_stop || !tx_enable;
  assign w_pop       = w_fall && w_last_slot && !w_stop;
  assign w_have_pair = (w_count != '0);

  assign w_load = w_have_pair ?
    {I2S_WIDTH'(pad_sample(MAX_SAMPLE_W'(w_head[2*AUDIO_WIDTH-1:AUDIO_WIDTH]), AUDIO_WIDTH, I2S_WIDTH)),
     I2S_WIDTH'(pad_sample(MAX_SAMPLE_W'(w_head[AUDIO_WIDTH-1:0]), AUDIO_WIDTH, I2S_WIDTH))} : '0;

  // START has only the dummy slot before slot 0, so its first fall jumps to the last slot.
  assign w_next_slot = (r_state == START) ? SW'(SLOTS - 1) : r_slot + 1'b1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_div_cnt  <= '0;
      r_slot     <= '0;
      r_frame_sr <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_data     <= 1'b0;
      r_underrun <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_underrun <= w_pop && !w_have_pair;
      case (r_state)
        IDLE: begin
          r_div_cnt  <= '0;
          r_slot     <= '0;
          r_frame_sr <= '0;
          r_bclk     <= 1'b0;
          r_lrclk    <= 1'b0;
          r_data     <= 1'b0;
          r_stop     <= 1'b0;
          if (tx_enable) r_state <= START;
        end
        default: begin
          if (!tx_enable) r_stop <= 1'b1;
          if (w_tc) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
          if (w_fall) begin
            if (w_last_slot && w_stop) begin
              r_state    <= IDLE;
              r_slot     <= '0;
              r_lrclk    <= 1'b0;
              r_data     <= 1'b0;
              r_frame_sr <= '0;
              r_stop     <= 1'b0;
            end else if (w_last_slot) begin
              r_state    <= RUN;
              r_slot     <= '0;
              r_lrclk    <= (slot_channel(0, I2S_WIDTH) == RIGHT);
              r_data     <= w_load[SLOTS-1];
              r_frame_sr <= w_load << 1;
            end else begin
              r_slot     <= w_next_slot;
              r_lrclk    <= (slot_channel(int'(w_next_slot), I2S_WIDTH) == RIGHT);
              r_data     <= r_frame_sr[SLOTS-1];
              r_frame_sr <= r_frame_sr << 1;
            end
          end
        end
      endcase
    end
  end

  assign buffer_ready = !w_full;
  assign buffer_full  = w_full;
  assign buffer_empty = w_empty;
  assign underrun     = r_underrun;
  assign i2s_bclk     = r_bclk;
  assign i2s_lrclk    = r_lrclk;
  assign i2s_data     = r_data;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/buf_audio_out.md
Name: buf_audio_out

Overview:
- I2S master transmitter with a stereo sample-pair FIFO; the transmit-side counterpart of the buf_audio_in receive path.
- Accepts left/right sample pairs in the sys_clk domain and buffers them in a BUFFER_DEPTH-entry FIFO.
- Generates i2s_bclk and i2s_lrclk by dividing sys_clk, and serialises the samples MSB-first in Philips I2S format towards the DAC/codec.
- Single clock domain, so no CDC logic is needed.

Parameters:
- I2S_WIDTH, 24: bits per channel slot on the wire.
- AUDIO_WIDTH, 24: width of the parallel sample inputs.
- BUFFER_DEPTH, 4: FIFO depth in L/R pairs; must be a power of 2 and at least 2.
- BCLK_DIV, 2: sys_clk cycles per bclk half-period; must be at least 1.

Ports:
- sys_clk  in  1  system clock; all logic runs on its rising edge.
- sys_rst  in  1  reset: one clock, synchronous, active-high.
- tx_enable  in  1  run the serial interface.
- audio_left_in  in  AUDIO_WIDTH  left sample.
- audio_right_in  in  AUDIO_WIDTH  right sample.
- sample_valid  in  1  write request for the pair.
- buffer_ready  out  1  pair accepted when sample_valid and buffer_ready are both high; equals not buffer_full.
- buffer_full  out  1  FIFO holds BUFFER_DEPTH pairs.
- buffer_empty  out  1  FIFO holds 0 pairs.
- underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- i2s_bclk  out  1  bit clock; period is 2*BCLK_DIV sys_clk cycles.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_data  out  1  serial data; changes on bclk falling edge, receiver samples on rising edge.

Behaviour:
- Reset values while sys_rst is high:
  - i2s_bclk=0, i2s_lrclk=0, i2s_data=0, underrun=0.
  - buffer_empty=1, buffer_full=0, buffer_ready=1.
  - FIFO pointers and count = 0; divider, slot counter and state cleared.
- Reset applied mid-frame aborts the frame immediately and discards all buffered pairs.
- All outputs are registered and change only on sys_clk rising edges.
- Width rule: if AUDIO_WIDTH < I2S_WIDTH, the sample is left-justified with zero LSBs. If AUDIO_WIDTH > I2S_WIDTH, the LSBs are truncated.
- Divider: div_cnt counts 0..BCLK_DIV-1 while not IDLE. At terminal count, bclk toggles; a 1->0 toggle is a "fall event".
- Slots: slot counter s runs 0..2*I2S_WIDTH-1 and advances on each fall event.
  - Word select: i2s_lrclk in slot s = (((s+1) mod 2W) >= W), where W = I2S_WIDTH. This gives lrclk one slot ahead of the data (I2S one-bit delay).
  - Data: i2s_data in slot s = frame_sr[2W-1-s], where frame_sr = {L_word, R_word}.
- FIFO pop happens on the fall event that begins slot 0; frame_sr loads from the FIFO head in that same cycle.
  - If the FIFO is empty at that point: frame_sr loads all zeros and underrun pulses for one cycle.
  - Write and pop in the same cycle with the FIFO empty: the pop sees empty and underruns; the write is stored.
  - Write with the FIFO full: not accepted, because buffer_ready=0 even if a pop happens in the same cycle. A pop and a write never change the count by a net of zero when full.
  - FIFO pointers wrap modulo BUFFER_DEPTH.
- State machine:
  - IDLE: bclk=0, lrclk=0, data=0. On tx_enable=1, go to START.
  - START: first event is a bclk rise after BCLK_DIV cycles. The first fall event begins a dummy slot 2W-1 (lrclk=0, data=0). The next fall event enters slot 0, goes to RUN, and pops.
  - RUN: free-running frames. If tx_enable=0 is sampled, finish the current frame through slot 2W-1. At the next fall event that would begin slot 0, go to IDLE without popping; outputs return to IDLE values.
- Latency: the MSB of the first left word appears on i2s_data 4*BCLK_DIV sys_clk cycles after tx_enable is sampled high (FIFO non-empty).

Decomposition:
- Package buf_audio_pkg holds:
  - SLOTS_PER_FRAME = 2*I2S_WIDTH.
  - Typedef lr_sel_t, enum LEFT=0, RIGHT=1.
  - State enum tx_state_t {IDLE, START, RUN}.
  - Width-adjust function pad_sample().
- One sub-module, sample_pair_fifo: synchronous FIFO of {L,R} pairs with full/empty/count outputs.
- Top-level contents: divider, slot counter, FSM and shift register.

Test Plan:
1. Reset then idle: hold sys_rst for 5 cycles -> all outputs at reset values; buffer_ready=1; bclk static for 200 cycles.
2. Single pair: write L=0x123456, R=0xABCDEF, then tx_enable=1 (BCLK_DIV=2) -> first data bit at cycle 8; the model receiver captures 0x123456 while lrclk=0 and 0xABCDEF while lrclk=1; frame = 192 cycles.
3. Underrun: continue the previous test with no further writes -> underrun pulses at the next frame start and the frame transmits 0x000000/0x000000.
4. Fill and full: write 5 pairs 0x100000..0x100004 with tx_enable=0 -> buffer_full after 4; 5th write refused; enable -> transmitted 0x100000..0x100003 in order, then underrun.
5. Stop mid-frame: drop tx_enable at slot 10 -> the frame completes all 48 slots, then IDLE with bclk=0 and no extra pop.
6. Reset mid-frame at slot 30 -> the next cycle shows all outputs at reset values and buffer_empty=1.
